// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, FSM state encodings, write beat payload.
package axi_lite_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_HAVE_ADDR,
        WR_HAVE_DATA,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_DATA
    } rd_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } wr_beat_t;

endpackage

// File: rtl/axi_lite_slave_regs_if.sv
// AXI4-Lite slave-side bus bundle with master and slave views.
interface axi_lite_slave_regs_if
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] S_AXI_AWADDR;
    logic              S_AXI_AWVALID;
    logic              S_AXI_AWREADY;
    logic [DATA_W-1:0] S_AXI_WDATA;
    logic [STRB_W-1:0] S_AXI_WSTRB;
    logic              S_AXI_WVALID;
    logic              S_AXI_WREADY;
    logic [1:0]        S_AXI_BRESP;
    logic              S_AXI_BVALID;
    logic              S_AXI_BREADY;
    logic [ADDR_W-1:0] S_AXI_ARADDR;
    logic              S_AXI_ARVALID;
    logic              S_AXI_ARREADY;
    logic [DATA_W-1:0] S_AXI_RDATA;
    logic [1:0]        S_AXI_RRESP;
    logic              S_AXI_RVALID;
    logic              S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
               S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
               S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

endinterface

// File: rtl/axi_lite_strb_merge.sv
// Byte-lane merge: lanes with strobe set take the new data, others keep the old.
module axi_lite_strb_merge
    import axi_lite_pkg::*;
(
    input  logic [DATA_W-1:0] old_data,
    input  logic [DATA_W-1:0] new_data,
    input  logic [STRB_W-1:0] strb,
    output logic [DATA_W-1:0] merged
);

    always_comb begin
        merged = old_data;
        for (int b = 0; b < int'(STRB_W); b++) begin
            if (strb[b]) merged[8*b +: 8] = new_data[8*b +: 8];
        end
    end

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite register file with independent read/write FSMs and per-register write pulses.
// Define AXIL_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axi_lite_slave_regs
    import axi_lite_pkg::*;
#(
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_NUM_REGS         = 16
)(
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESET,
    axi_lite_slave_regs_if.slave                   s_axi,
    output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_o,
    output logic [C_NUM_REGS-1:0]                  wr_pulse_o
);

    localparam int unsigned ADDR_W = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned REG_W  = C_S_AXI_DATA_WIDTH;
    localparam int unsigned IDX_W  = $clog2(C_NUM_REGS);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(C_NUM_REGS * 4);

`ifdef AXIL_SLVERR_EN
    localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;

    logic              awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]        bresp_q, rresp_q;
    logic [REG_W-1:0]  rdata_q;
    logic [ADDR_W-1:0] awaddr_q;
    wr_beat_t          wbeat_q, wr_beat;
    logic [REG_W-1:0]  regs_q [C_NUM_REGS];

    logic              aw_hs, w_hs, ar_hs, wr_commit;
    logic [ADDR_W-1:0] wr_addr;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic              wr_in_range, rd_in_range;
    logic [REG_W-1:0]  merged;

    assign aw_hs = awready_q & s_axi.S_AXI_AWVALID;
    assign w_hs  = wready_q  & s_axi.S_AXI_WVALID;
    assign ar_hs = arready_q & s_axi.S_AXI_ARVALID;

    // Completing beat may arrive on the commit edge itself, so bypass the capture flops
    assign wr_addr     = aw_hs ? s_axi.S_AXI_AWADDR : awaddr_q;
    assign wr_idx      = wr_addr[IDX_W+1:2];
    assign wr_in_range = wr_addr < ADDR_LIMIT;
    assign rd_idx      = s_axi.S_AXI_ARADDR[IDX_W+1:2];
    assign rd_in_range = s_axi.S_AXI_ARADDR < ADDR_LIMIT;

    always_comb begin
        wr_beat = wbeat_q;
        if (w_hs) begin
            wr_beat.data = s_axi.S_AXI_WDATA;
            wr_beat.strb = s_axi.S_AXI_WSTRB;
        end
    end

    axi_lite_strb_merge u_merge (
        .old_data (regs_q[wr_idx]),
        .new_data (wr_beat.data),
        .strb     (wr_beat.strb),
        .merged   (merged)
    );

    // Write FSM next state
    always_comb begin
        wr_next   = wr_state;
        wr_commit = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                if (aw_hs && w_hs) wr_next = WR_RESP;
                else if (aw_hs)    wr_next = WR_HAVE_ADDR;
                else if (w_hs)     wr_next = WR_HAVE_DATA;
            end
            WR_HAVE_ADDR: if (w_hs)  wr_next = WR_RESP;
            WR_HAVE_DATA: if (aw_hs) wr_next = WR_RESP;
            WR_RESP:      if (bvalid_q && s_axi.S_AXI_BREADY) wr_next = WR_IDLE;
            default:      wr_next = WR_IDLE;
        endcase
        wr_commit = (wr_state != WR_RESP) && (wr_next == WR_RESP);
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            wr_state   <= WR_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            awaddr_q   <= '0;
            wbeat_q    <= '0;
            wr_pulse_o <= '0;
        end else begin
            wr_state   <= wr_next;
            awready_q  <= (wr_next == WR_IDLE) || (wr_next == WR_HAVE_DATA);
            wready_q   <= (wr_next == WR_IDLE) || (wr_next == WR_HAVE_ADDR);
            bvalid_q   <= (wr_next == WR_RESP);
            wr_pulse_o <= '0;
            if (aw_hs) awaddr_q <= s_axi.S_AXI_AWADDR;
            if (w_hs)  wbeat_q  <= wr_beat;
            if (wr_commit) begin
                bresp_q <= wr_in_range ? RESP_OKAY : OOR_RESP;
                if (wr_in_range) wr_pulse_o <= C_NUM_REGS'(1) << wr_idx;
            end
        end
    end

    // Register storage; out-of-range writes are dropped
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < int'(C_NUM_REGS); i++) regs_q[i] <= '0;
        end else if (wr_commit && wr_in_range) begin
            regs_q[wr_idx] <= merged;
        end
    end

    // Read FSM next state
    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE: if (ar_hs) rd_next = RD_DATA;
            RD_DATA: if (rvalid_q && s_axi.S_AXI_RREADY) rd_next = RD_IDLE;
            default: rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            rd_state  <= RD_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            rd_state  <= rd_next;
            arready_q <= (rd_next == RD_IDLE);
            rvalid_q  <= (rd_next == RD_DATA);
            if (ar_hs) begin
                rdata_q <= rd_in_range ? regs_q[rd_idx] : '0;
                rresp_q <= rd_in_range ? RESP_OKAY : OOR_RESP;
            end
        end
    end

    for (genvar g = 0; g < int'(C_NUM_REGS); g++) begin : g_regs_out
        assign regs_o[g*REG_W +: REG_W] = regs_q[g];
    end

    assign s_axi.S_AXI_AWREADY = awready_q;
    assign s_axi.S_AXI_WREADY  = wready_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Self-checking bench for axi_lite_slave_regs against an array-based register model.
module tb_axi_lite_slave_regs;

    localparam int unsigned NREGS = 16;

`ifdef AXIL_SLVERR_EN
    localparam logic [1:0] OOR_RESP = 2'b10;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_lite_slave_regs_if #(.ADDR_W(32)) bus ();
    logic [NREGS*32-1:0] regs;
    logic [NREGS-1:0]    pulse;

    axi_lite_slave_regs #(
        .C_S_AXI_ADDR_WIDTH (32),
        .C_S_AXI_DATA_WIDTH (32),
        .C_NUM_REGS         (NREGS)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .s_axi        (bus),
        .regs_o       (regs),
        .wr_pulse_o   (pulse)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] model [NREGS];

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                                input logic [3:0] strb);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] reg_of(input int i);
        return regs[i*32 +: 32];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < int'(NREGS); i++) model[i] = 32'h0;
    endtask

    task automatic idle_bus();
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_AWADDR = '0;
        bus.S_AXI_WVALID  = 1'b0; bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB = '0;
        bus.S_AXI_BREADY  = 1'b0;
        bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_ARADDR = '0;
        bus.S_AXI_RREADY  = 1'b0;
    endtask

    // Drives one write with independent AW/W/B delays; reports response, pulses seen, BVALID cycles.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly,
                            output logic [1:0] bresp, output logic [15:0] pulse_or,
                            output int pulse_cycles, output int bcycles,
                            output bit b_ok, output bit timeout);
        bit aw_done, w_done, b_done;
        int cyc;
        logic [1:0] first_resp;
        aw_done = 0; w_done = 0; b_done = 0; cyc = 0;
        bresp = 2'b00; pulse_or = '0; pulse_cycles = 0; bcycles = 0; b_ok = 1; first_resp = 2'b00;
        while (!b_done && cyc < 200) begin
            @(negedge clk);
            if (pulse !== '0) begin pulse_or |= pulse; pulse_cycles++; end
            if (bus.S_AXI_BVALID === 1'b1) begin
                if (bcycles == 0) first_resp = bus.S_AXI_BRESP;
                else if (bus.S_AXI_BRESP !== first_resp) b_ok = 0;
                if (bus.S_AXI_AWREADY !== 1'b0 || bus.S_AXI_WREADY !== 1'b0) b_ok = 0;
                bcycles++;
            end
            bus.S_AXI_AWADDR  = addr;
            bus.S_AXI_AWVALID = (!aw_done && cyc >= aw_dly);
            bus.S_AXI_WDATA   = data;
            bus.S_AXI_WSTRB   = strb;
            bus.S_AXI_WVALID  = (!w_done && cyc >= w_dly);
            bus.S_AXI_BREADY  = (bus.S_AXI_BVALID === 1'b1) && (bcycles > b_dly);
            if (bus.S_AXI_AWVALID && bus.S_AXI_AWREADY === 1'b1) aw_done = 1;
            if (bus.S_AXI_WVALID && bus.S_AXI_WREADY === 1'b1) w_done = 1;
            if (bus.S_AXI_BREADY) begin bresp = bus.S_AXI_BRESP; b_done = 1; end
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        if (pulse !== '0) begin pulse_or |= pulse; pulse_cycles++; end
        idle_bus();
        timeout = !b_done;
    endtask

    // Drives one read, holding RREADY low for r_dly RVALID cycles; checks hold stability.
    task automatic do_read(input logic [31:0] addr, input int r_dly,
                           output logic [31:0] rdata, output logic [1:0] rresp,
                           output int rcycles, output bit stable, output bit timeout);
        bit ar_done, r_done;
        int cyc;
        logic [31:0] first_data;
        logic [1:0]  first_resp;
        ar_done = 0; r_done = 0; cyc = 0; rcycles = 0; stable = 1;
        rdata = '0; rresp = '0; first_data = '0; first_resp = '0;
        while (!r_done && cyc < 200) begin
            @(negedge clk);
            if (bus.S_AXI_RVALID === 1'b1) begin
                if (rcycles == 0) begin
                    first_data = bus.S_AXI_RDATA; first_resp = bus.S_AXI_RRESP;
                end else if (bus.S_AXI_RDATA !== first_data || bus.S_AXI_RRESP !== first_resp) begin
                    stable = 0;
                end
                if (bus.S_AXI_ARREADY !== 1'b0) stable = 0;
                rcycles++;
            end
            bus.S_AXI_ARADDR  = addr;
            bus.S_AXI_ARVALID = !ar_done;
            bus.S_AXI_RREADY  = (bus.S_AXI_RVALID === 1'b1) && (rcycles > r_dly);
            if (bus.S_AXI_ARVALID && bus.S_AXI_ARREADY === 1'b1) ar_done = 1;
            if (bus.S_AXI_RREADY) begin
                rdata = bus.S_AXI_RDATA; rresp = bus.S_AXI_RRESP; r_done = 1;
            end
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        idle_bus();
        timeout = !r_done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_bus();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID,
             bus.S_AXI_RVALID, bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_RDATA, pulse} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got ready=%b%b%b bv=%b rv=%b bresp=%b rresp=%b rdata=%h pulse=%h, expected all 0",
                     bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID,
                     bus.S_AXI_RVALID, bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_RDATA, pulse);
        end
        n_vec++;
        if (regs !== '0) begin
            n_err++; $display("FAIL reset_regs: got %h expected 0", regs);
        end
        rst = 1'b0;
        clear_model();
        @(posedge clk);
        #1;
        n_vec++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b111) begin
            n_err++;
            $display("FAIL reset_release_ready: got %b%b%b expected 111",
                     bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY);
        end
    endtask

    task automatic test_same_cycle_write();
        @(negedge clk);
        bus.S_AXI_AWADDR = 32'h4; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = 32'hDEADBEEF; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        @(posedge clk);
        #1;
        model[1] = merge_bytes(model[1], 32'hDEADBEEF, 4'hF);
        n_vec++;
        if (bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_BRESP !== 2'b00) begin
            n_err++; $display("FAIL same_cycle_b: got bvalid=%b bresp=%b expected 1/00",
                              bus.S_AXI_BVALID, bus.S_AXI_BRESP);
        end
        n_vec++;
        if (reg_of(1) !== model[1]) begin
            n_err++; $display("FAIL same_cycle_reg1: got %h expected %h", reg_of(1), model[1]);
        end
        n_vec++;
        if (pulse !== 16'h0002) begin
            n_err++; $display("FAIL same_cycle_pulse: got %h expected 0002", pulse);
        end
        @(negedge clk);
        idle_bus();
        bus.S_AXI_BREADY = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (bus.S_AXI_BVALID !== 1'b0 || pulse !== '0 || bus.S_AXI_AWREADY !== 1'b1) begin
            n_err++; $display("FAIL same_cycle_done: got bvalid=%b pulse=%h awready=%b expected 0/0000/1",
                              bus.S_AXI_BVALID, pulse, bus.S_AXI_AWREADY);
        end
        @(negedge clk);
        idle_bus();
    endtask

    task automatic test_split_write();
        logic [1:0] bresp; logic [15:0] por; int pc, bc; bit ok, to;
        do_write(32'h4, 32'h11223344, 4'h5, 3, 0, 5, bresp, por, pc, bc, ok, to);
        model[1] = merge_bytes(model[1], 32'h11223344, 4'h5);
        n_vec++;
        if (reg_of(1) !== 32'hDE22BE44) begin
            n_err++; $display("FAIL split_reg1: got %h expected de22be44", reg_of(1));
        end
        n_vec++;
        if (to || !ok || bc != 6 || bresp !== 2'b00) begin
            n_err++; $display("FAIL split_bhold: got timeout=%0d ok=%0d bcycles=%0d bresp=%b expected 0/1/6/00",
                              to, ok, bc, bresp);
        end
        n_vec++;
        if (por !== 16'h0002 || pc != 1) begin
            n_err++; $display("FAIL split_pulse: got %h x%0d expected 0002 x1", por, pc);
        end
    endtask

    task automatic test_read_stall();
        logic [31:0] rd; logic [1:0] rr; int rc; bit st, to;
        do_read(32'h4, 4, rd, rr, rc, st, to);
        n_vec++;
        if (rd !== model[1] || rr !== 2'b00) begin
            n_err++; $display("FAIL read_stall_data: got %h/%b expected %h/00", rd, rr, model[1]);
        end
        n_vec++;
        if (to || !st || rc != 5) begin
            n_err++; $display("FAIL read_stall_hold: got timeout=%0d stable=%0d rcycles=%0d expected 0/1/5",
                              to, st, rc);
        end
    endtask

    task automatic test_collision();
        logic [31:0] old_v, rd; logic [1:0] rr; int rc; bit st, to;
        old_v = model[2];
        @(negedge clk);
        bus.S_AXI_AWADDR = 32'h8; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = 32'hA5A5A5A5; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        bus.S_AXI_ARADDR = 32'h8; bus.S_AXI_ARVALID = 1'b1;
        @(posedge clk);
        #1;
        model[2] = 32'hA5A5A5A5;
        n_vec++;
        if (bus.S_AXI_RVALID !== 1'b1 || bus.S_AXI_RDATA !== old_v || bus.S_AXI_BVALID !== 1'b1) begin
            n_err++; $display("FAIL collision_old: got rv=%b rdata=%h bv=%b expected 1/%h/1",
                              bus.S_AXI_RVALID, bus.S_AXI_RDATA, bus.S_AXI_BVALID, old_v);
        end
        @(negedge clk);
        idle_bus();
        bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
        @(posedge clk);
        @(negedge clk);
        idle_bus();
        do_read(32'h8, 0, rd, rr, rc, st, to);
        n_vec++;
        if (to || rd !== model[2]) begin
            n_err++; $display("FAIL collision_new: got %h timeout=%0d expected %h", rd, to, model[2]);
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0] bresp, rr; logic [15:0] por; int pc, bc, rc; bit ok, to, st;
        logic [NREGS*32-1:0] snap;
        logic [31:0] rd, d;
        snap = regs;
        do_write(32'h40, $urandom, 4'hF, 0, 1, 0, bresp, por, pc, bc, ok, to);
        n_vec++;
        if (to || bresp !== OOR_RESP || por !== '0) begin
            n_err++; $display("FAIL oor_write: got bresp=%b pulse=%h timeout=%0d expected %b/0000/0",
                              bresp, por, to, OOR_RESP);
        end
        n_vec++;
        if (regs !== snap) begin
            n_err++; $display("FAIL oor_regs: got %h expected %h", regs, snap);
        end
        do_read(32'h40, 1, rd, rr, rc, st, to);
        n_vec++;
        if (to || rd !== 32'h0 || rr !== OOR_RESP) begin
            n_err++; $display("FAIL oor_read: got %h/%b expected 00000000/%b", rd, rr, OOR_RESP);
        end
        d = $urandom;
        do_write(32'h3F, d, 4'hF, 1, 0, 0, bresp, por, pc, bc, ok, to);
        model[15] = d;
        n_vec++;
        if (to || bresp !== 2'b00 || por !== 16'h8000 || reg_of(15) !== model[15]) begin
            n_err++; $display("FAIL last_reg_write: got bresp=%b pulse=%h reg=%h expected 00/8000/%h",
                              bresp, por, reg_of(15), model[15]);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] bresp; logic [15:0] por; int pc, bc; bit ok, to;
        logic [31:0] d;
        @(negedge clk);
        bus.S_AXI_AWADDR = 32'hC; bus.S_AXI_AWVALID = 1'b1;
        @(posedge clk);
        @(negedge clk);
        idle_bus();
        n_vec++;
        if (bus.S_AXI_AWREADY !== 1'b0 || bus.S_AXI_WREADY !== 1'b1) begin
            n_err++; $display("FAIL mid_have_addr: got awready=%b wready=%b expected 0/1",
                              bus.S_AXI_AWREADY, bus.S_AXI_WREADY);
        end
        rst = 1'b1;
        bus.S_AXI_WDATA = 32'hFFFFFFFF; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clear_model();
        n_vec++;
        if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID,
             bus.S_AXI_RVALID, bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_RDATA, pulse} !== '0
            || regs !== '0) begin
            n_err++; $display("FAIL mid_reset_state: got bv=%b pulse=%h regs=%h expected all 0",
                              bus.S_AXI_BVALID, pulse, regs);
        end
        idle_bus();
        rst = 1'b0;
        d = $urandom;
        do_write(32'hC, d, 4'hF, 0, 2, 1, bresp, por, pc, bc, ok, to);
        model[3] = d;
        n_vec++;
        if (to || bresp !== 2'b00 || por !== 16'h0008 || pc != 1 || reg_of(3) !== model[3]) begin
            n_err++; $display("FAIL mid_after_write: got bresp=%b pulse=%h x%0d reg=%h expected 00/0008 x1/%h",
                              bresp, por, pc, reg_of(3), model[3]);
        end
    endtask

    task automatic test_random();
        logic [1:0] bresp, rr; logic [15:0] por, exp_p; int pc, bc, rc, idx; bit ok, to, st, in_r;
        logic [31:0] addr, d, rd; logic [3:0] s;
        for (int n = 0; n < 40; n++) begin
            idx  = int'($urandom_range(0, 17));
            addr = 32'(idx * 4) + 32'($urandom_range(0, 3));
            d    = $urandom;
            s    = 4'($urandom_range(0, 15));
            in_r = (idx < int'(NREGS));
            do_write(addr, d, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), bresp, por, pc, bc, ok, to);
            exp_p = '0;
            if (in_r) begin
                model[idx] = merge_bytes(model[idx], d, s);
                exp_p = 16'(1) << idx;
            end
            n_vec++;
            if (to || !ok || bresp !== (in_r ? 2'b00 : OOR_RESP) || por !== exp_p || pc != (in_r ? 1 : 0)) begin
                n_err++; $display("FAIL rand_write[%0d] addr=%h: got bresp=%b pulse=%h x%0d ok=%0d to=%0d expected %b/%h",
                                  n, addr, bresp, por, pc, ok, to, in_r ? 2'b00 : OOR_RESP, exp_p);
            end
            if ((n % 3) == 0) begin
                idx  = int'($urandom_range(0, 17));
                addr = 32'(idx * 4) + 32'($urandom_range(0, 3));
                do_read(addr, int'($urandom_range(0, 3)), rd, rr, rc, st, to);
                n_vec++;
                if (to || !st || rd !== (idx < int'(NREGS) ? model[idx % int'(NREGS)] : 32'h0)
                    || rr !== (idx < int'(NREGS) ? 2'b00 : OOR_RESP)) begin
                    n_err++; $display("FAIL rand_read addr=%h: got %h/%b stable=%0d", addr, rd, rr, st);
                end
            end
        end
        for (int i = 0; i < int'(NREGS); i++) begin
            do_read(32'(i * 4), 0, rd, rr, rc, st, to);
            n_vec++;
            if (to || rd !== model[i] || reg_of(i) !== model[i]) begin
                n_err++; $display("FAIL readback[%0d]: got rdata=%h regs_o=%h expected %h",
                                  i, rd, reg_of(i), model[i]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        clear_model();
        test_reset();
        test_same_cycle_write();
        test_split_write();
        test_read_stall();
        test_collision();
        test_out_of_range();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi_lite_slave_regs.md
AXI_LITE_SLAVE_REGS -- requirements
Module: axi_lite_slave_regs

Interface
REQ-001 The block SHALL use one clock, S_AXI_ACLK; its reset, S_AXI_ARESET, SHALL be synchronous and active-high.
REQ-002 Parameters SHALL be:
- C_S_AXI_ADDR_WIDTH, default 32, address width.
- C_S_AXI_DATA_WIDTH, default 32, data width; only 32 is supported.
- C_NUM_REGS, default 16, register count; must be a power of 2, from 2 to 256.
REQ-003 Ports SHALL be:
- S_AXI_ACLK in 1: clock.
- S_AXI_ARESET in 1: sync reset, active-high.
- S_AXI_AWADDR in ADDR_W: write address. S_AXI_AWVALID in 1. S_AXI_AWREADY out 1.
- S_AXI_WDATA in 32: write data. S_AXI_WSTRB in 4: byte enables. S_AXI_WVALID in 1. S_AXI_WREADY out 1.
- S_AXI_BRESP out 2: write response. S_AXI_BVALID out 1. S_AXI_BREADY in 1.
- S_AXI_ARADDR in ADDR_W: read address. S_AXI_ARVALID in 1. S_AXI_ARREADY out 1.
- S_AXI_RDATA out 32: read data. S_AXI_RRESP out 2: read response. S_AXI_RVALID out 1. S_AXI_RREADY in 1.
- regs_o out C_NUM_REGS*32: all registers, flattened; register n occupies bits [32n+31:32n].
- wr_pulse_o out C_NUM_REGS: one-cycle pulse per register written.

Function
REQ-004 Address decode SHALL be: index = addr[IDX_W+1:2], where IDX_W = log2(C_NUM_REGS); an address is in range iff addr < C_NUM_REGS*4; addr[1:0] is ignored.
REQ-005 The write FSM SHALL have the states WR_IDLE, WR_HAVE_ADDR, WR_HAVE_DATA and WR_RESP.
REQ-006 AWREADY SHALL be 1 in WR_IDLE and WR_HAVE_DATA; WREADY SHALL be 1 in WR_IDLE and WR_HAVE_ADDR; both SHALL be 0 in WR_RESP.
REQ-007 Write FSM transitions SHALL be:
- WR_IDLE: AW handshake only -> WR_HAVE_ADDR (address captured); W handshake only -> WR_HAVE_DATA (data and strobe captured); both in the same cycle -> WR_RESP.
- WR_HAVE_ADDR: W handshake -> WR_RESP.
- WR_HAVE_DATA: AW handshake -> WR_RESP.
- WR_RESP: BVALID && BREADY -> WR_IDLE.
REQ-008 The register update SHALL occur on the edge that enters WR_RESP, merging bytes per WSTRB (strobe 0 keeps the old byte); BVALID SHALL be 1 from the next cycle.
REQ-009 wr_pulse_o[index] SHALL be 1 for exactly the one cycle after the update edge; in-range writes with WSTRB=0 SHALL still pulse.
REQ-010 BVALID SHALL stay high, with BRESP stable, until BREADY is sampled high.
REQ-011 The read FSM SHALL have the states RD_IDLE (ARREADY=1) and RD_DATA (RVALID=1, ARREADY=0).
REQ-012 An AR handshake SHALL register RDATA and RRESP on that edge; RVALID SHALL be 1 from the next cycle; RD_DATA -> RD_IDLE on RVALID && RREADY.
REQ-013 RDATA and RRESP SHALL be held stable while RVALID=1 and RREADY=0.
REQ-014 A read and a write committing to the same register on the same edge SHALL return the pre-write value.
REQ-015 The read and write channels SHALL operate fully independently and concurrently.
REQ-016 Each channel SHALL accept at most one outstanding transaction; no AW or W SHALL be accepted while BVALID=1.
REQ-017 regs_o SHALL reflect register contents combinationally from the register flops, with no additional latency.

Reset
REQ-018 While S_AXI_ARESET=1, all registers SHALL be cleared to 0, both FSMs SHALL go to IDLE, and the following SHALL be 0: AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA, wr_pulse_o.
REQ-019 The ready outputs SHALL be 0 during reset and SHALL become 1 in the first cycle after reset deasserts.
REQ-020 Reset mid-transaction SHALL abandon the transaction: no register update and no response.

Configuration
REQ-021 With AXIL_SLVERR_EN defined:
- Out-of-range writes SHALL be dropped and SHALL return BRESP=2'b10.
- Out-of-range reads SHALL return RDATA=0 and RRESP=2'b10.
REQ-022 Without AXIL_SLVERR_EN:
- Out-of-range writes SHALL be dropped and SHALL return OKAY (2'b00).
- Out-of-range reads SHALL return RDATA=0 and OKAY.
REQ-023 In-range accesses SHALL always return OKAY.
REQ-024 No wr_pulse_o SHALL be generated for an out-of-range write, in either configuration.

Structure
REQ-025 The shared package axi_lite_pkg SHALL hold:
- RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10.
- The write and read FSM state encodings.
REQ-026 The byte-lane merge SHALL be a sub-module, axi_lite_strb_merge (old, new, strb -> merged), used by the write path.

Verification
REQ-027 Reset, then AW 0x04 and W 0xDEADBEEF (strb 0xF) in the same cycle -> BVALID one cycle later, BRESP=00, regs_o[63:32]=0xDEADBEEF, wr_pulse_o=0x0002.
REQ-028 W 0x11223344 (strb 0x5) to reg 1 three cycles before AW 0x04 -> reg1=0xDE22BE44; BVALID held while BREADY is low for 5 cycles.
REQ-029 AR 0x04 with RREADY low for 4 cycles -> RVALID=1 and RDATA=0xDE22BE44 stable throughout; ARREADY=0 until the RVALID/RREADY handshake.
REQ-030 Read and write of reg 2 (write 0xA5A5A5A5) committing on the same edge -> RDATA=0x00000000; the next read returns 0xA5A5A5A5.
REQ-031 AW 0x40 (C_NUM_REGS=16) -> no pulse, registers unchanged, BRESP=10 with AXIL_SLVERR_EN, 00 without; AR 0x40 -> RDATA=0, same RRESP rule.
REQ-032 Assert reset while in WR_HAVE_ADDR -> all outputs 0, no register change; a subsequent full write completes normally.
